addsub_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 20-bit adder/subtractor between two requesters. Each requester presents an operation (add or subtract) with two 20-bit operands over a valid/ready handshake. The block grants one requester per cycle, computes the result, and holds it in a single output register until a downstream consumer takes it. It sits between the register-file/ALU control logic and the shared arithmetic unit.

---
 rtl/addsub_arbiter.sv | 61 ++++++
 tb/tb_addsub_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin share of one add/sub unit between two requesters with a single output register
module addsub_arbiter #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_cout
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_d;
  logic last, grant, can_accept, accept, op;
  logic [WIDTH-1:0] a, b;
  logic [WIDTH:0] sum;
  assign can_accept = state == EMPTY || rsp_ready;
  assign grant = req1_valid && (!req0_valid || !last);
  assign req0_ready = !rst && !grant && req0_valid && can_accept;
  assign req1_ready = !rst && grant && req1_valid && can_accept;
  assign accept = req0_ready || req1_ready;
  assign op = grant ? req1_op : req0_op;
  assign a = grant ? req1_a : req0_a;
  assign b = grant ? req1_b : req0_b;
  // subtract as a + ~b + 1 so cout doubles as the not-borrow flag
  assign sum = {1'b0, a} + {1'b0, op ? ~b : b} + {{WIDTH{1'b0}}, op};
  assign rsp_valid = state == FULL;
  always_comb begin
    state_d = state;
    if (accept) state_d = FULL;
    else if (rsp_ready) state_d = EMPTY;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      last <= 1'b1;
      rsp_id <= 1'b0;
      rsp_out <= '0;
      rsp_cout <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        last <= grant;
        rsp_id <= grant;
        rsp_out <= sum[WIDTH-1:0];
        rsp_cout <= sum[WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed checks of arbitration, arithmetic, backpressure and reset
module tb_addsub_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid, req0_ready, req0_op, req1_valid, req1_ready, req1_op;
  logic [19:0] req0_a, req0_b, req1_a, req1_b, rsp_out;
  logic rsp_valid, rsp_ready, rsp_id, rsp_cout;
  int tests = 0, fails = 0;
  addsub_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_cout(rsp_cout)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic rsp(input string tag, input logic v, input logic id, input logic [19:0] o, input logic c);
    check({tag, "_valid"}, rsp_valid, v);
    check({tag, "_id"}, rsp_id, id);
    check({tag, "_out"}, rsp_out, o);
    check({tag, "_cout"}, rsp_cout, c);
  endtask
  initial begin
    logic [1:0] ids;
    req0_valid = 1; req0_op = 0; req0_a = 20'hFFFFF; req0_b = 20'h00001;
    req1_valid = 1; req1_op = 1; req1_a = 20'd5; req1_b = 20'd3;
    rsp_ready = 0;
    for (int i = 0; i < 2; i++) begin
      tick;
      check("rst_valid", rsp_valid, 0);
      check("rst_out", rsp_out, 0);
      check("rst_rdy0", req0_ready, 0);
      check("rst_rdy1", req1_ready, 0);
    end
    rst = 0;
    #1;
    check("post_rst_rdy0", req0_ready, 1);
    check("post_rst_rdy1", req1_ready, 0);
    req1_valid = 0; rsp_ready = 1;
    tick;
    rsp("add_ovf", 1, 0, 20'h00000, 1);
    req0_a = 20'h7FFFF;
    tick;
    rsp("add_mid", 1, 0, 20'h80000, 0);
    req0_valid = 0; req1_valid = 1;
    tick;
    rsp("sub_pos", 1, 1, 20'h00002, 1);
    req1_a = 20'd3; req1_b = 20'd5;
    tick;
    rsp("sub_neg", 1, 1, 20'hFFFFE, 0);
    req0_valid = 1; req0_a = 20'd1; req0_b = 20'd2;
    req1_a = 20'd10; req1_b = 20'd4;
    ids = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("cont_onehot", req0_ready & req1_ready, 0);
      tick;
      rsp("cont", 1, i[0], i[0] ? 20'd6 : 20'd3, i[0]);
    end
    req0_a = 20'h12345; req0_b = 20'h11111;
    tick;
    rsp("bp_acc", 1, 0, 20'h23456, 0);
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_rdy0", req0_ready, 0);
      check("bp_rdy1", req1_ready, 0);
      tick;
      rsp("bp_hold", 1, 0, 20'h23456, 0);
    end
    rsp_ready = 1;
    #1;
    check("bp_rel_rdy1", req1_ready, 1);
    tick;
    rsp("bp_refill", 1, 1, 20'd6, 1);
    rsp_ready = 0; rst = 1;
    #1;
    check("mid_rst_rdy0", req0_ready, 0);
    check("mid_rst_rdy1", req1_ready, 0);
    tick;
    rsp("mid_rst", 0, 0, 20'h0, 0);
    rst = 0;
    #1;
    check("refresh_rdy0", req0_ready, 1);
    tick;
    rsp("refresh", 1, 0, 20'h23456, 0);
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    tick;
    rsp("drain", 0, 0, 20'h23456, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
